// File: rtl/ttm_sequencer.sv
// ttm_sequencer: program counter and call/return stack with run/halt/single-step control.
// Define TTM_SEQ_STACK_GUARD_EN to add stack overflow/underflow detection and the FAULT state.
module ttm_sequencer #(
  parameter int PC_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    RUN,
  input  logic                    STEP,
  input  logic                    HALT_REQ,
  input  logic                    CLR_FAULT,
  input  logic [2:0]              OP,
  input  logic [PC_W-1:0]         TARGET,
  input  logic                    Z_FLAG,
  input  logic                    C_FLAG,
  output logic [PC_W-1:0]         PC,
  output logic [$clog2(DEPTH):0]  SP,
  output logic                    EXEC,
  output logic                    HALTED,
  output logic                    FAULT,
  output logic [1:0]              FAULT_CODE
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;
  localparam logic [2:0] OP_JMP = 3'd1, OP_JZ = 3'd2, OP_JC = 3'd3, OP_CALL = 3'd4, OP_RET = 3'd5, OP_HALT = 3'd6;
`ifdef TTM_SEQ_STACK_GUARD_EN
  typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_RUN, S_HALT} state_t;
`endif
  state_t          state, state_nx;
  logic [PC_W-1:0] stack [DEPTH];
  logic [PC_W-1:0] pc_nx, pc_inc, pop_val;
  logic [SW-1:0]   sp_nx;
  logic [AW-1:0]   push_idx;
  logic            run_q, step_q, commit, stack_fault, ovf, unf, push, leave_run, taken;
  assign pc_inc    = PC + PC_W'(1);
  assign ovf       = OP == OP_CALL && SP == SW'(DEPTH);
  assign unf       = OP == OP_RET && SP == '0;
  assign commit    = state == S_RUN || (state == S_HALT && STEP && !step_q);
  assign EXEC      = commit && !stack_fault;
  assign push      = EXEC && OP == OP_CALL;
  // a full stack without the guard overwrites the top entry instead of growing
  assign push_idx  = ovf ? AW'(DEPTH - 1) : SP[AW-1:0];
  assign pop_val   = unf ? '0 : stack[SP[AW-1:0] - AW'(1)];
  assign taken     = OP == OP_JMP || OP == OP_CALL || (OP == OP_JZ && Z_FLAG) || (OP == OP_JC && C_FLAG);
  assign leave_run = !RUN || HALT_REQ || OP == OP_HALT;
  assign HALTED    = state != S_RUN;
  always_comb begin
    pc_nx = !EXEC ? PC : taken ? TARGET : OP == OP_RET ? pop_val : pc_inc;
    sp_nx = !EXEC ? SP : (OP == OP_CALL && !ovf) ? SP + SW'(1) : (OP == OP_RET && !unf) ? SP - SW'(1) : SP;
`ifdef TTM_SEQ_STACK_GUARD_EN
    state_nx = state == S_RUN  ? (stack_fault ? S_FAULT : leave_run ? S_HALT : S_RUN) :
               state == S_HALT ? ((commit && stack_fault) ? S_FAULT : (RUN && !run_q) ? S_RUN : S_HALT) :
               (CLR_FAULT ? S_HALT : S_FAULT);
`else
    state_nx = state == S_RUN ? (leave_run ? S_HALT : S_RUN) : ((RUN && !run_q) ? S_RUN : S_HALT);
`endif
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= S_HALT;
      PC     <= '0;
      SP     <= '0;
      run_q  <= 1'b0;
      step_q <= 1'b1;
    end else begin
      state  <= state_nx;
      PC     <= pc_nx;
      SP     <= sp_nx;
      run_q  <= RUN;
      step_q <= STEP;
    end
  end
  always_ff @(posedge CLK) begin
    if (push) stack[push_idx] <= pc_inc;
  end
`ifdef TTM_SEQ_STACK_GUARD_EN
  logic [1:0] fault_code;
  assign stack_fault = ovf || unf;
  assign FAULT       = state == S_FAULT;
  assign FAULT_CODE  = fault_code;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) fault_code <= 2'b00;
    else if (commit && stack_fault) fault_code <= ovf ? 2'b01 : 2'b10;
    else if (state == S_FAULT && CLR_FAULT) fault_code <= 2'b00;
  end
`else
  logic unused_clr;
  assign unused_clr  = CLR_FAULT;
  assign stack_fault = 1'b0;
  assign FAULT       = 1'b0;
  assign FAULT_CODE  = 2'b00;
`endif
endmodule
